// File: rtl/sdram_arb_pkg.sv
// Shared types for the two-port SDRAM host arbiter: FSM states and request op encoding.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

endpackage

// File: rtl/sdram_host_arbiter_if.sv
// Host-side bus between the arbiter (master) and the single SDRAM controller (slave).
interface sdram_host_arbiter_if #(
    parameter int HADDR_WIDTH = 24,
    parameter int DATA_WIDTH  = 16
);

    // Handshake: the master pulses rd_enable or wr_enable for exactly one cycle with
    // haddr/data_input stable; the slave raises busy while the op runs and the op is
    // complete on the first cycle busy is low again, when data_output is valid for reads.
    logic [HADDR_WIDTH-1:0] haddr;
    logic [DATA_WIDTH-1:0]  data_input;
    logic [DATA_WIDTH-1:0]  data_output;
    logic                   busy;
    logic                   rd_enable;
    logic                   wr_enable;

    modport master (
        output haddr,
        output data_input,
        output rd_enable,
        output wr_enable,
        input  data_output,
        input  busy
    );

    modport slave (
        input  haddr,
        input  data_input,
        input  rd_enable,
        input  wr_enable,
        output data_output,
        output busy
    );

endinterface

// File: rtl/sdram_arb_port.sv
// One requester slot: latches a single request, then reports busy, read data,
// read-valid and timeout-error back to that requester.
module sdram_arb_port
    import sdram_arb_pkg::*;
#(
    parameter int HADDR_WIDTH = 24,
    parameter int DATA_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rd_enable,
    input  logic                   wr_enable,
    input  logic [HADDR_WIDTH-1:0] haddr,
    input  logic [DATA_WIDTH-1:0]  wdata,
    input  logic                   grant,
    input  logic                   done,
    input  logic                   abort,
    input  logic [DATA_WIDTH-1:0]  data_output,
    output logic                   pending,
    output logic [HADDR_WIDTH-1:0] req_haddr,
    output logic [DATA_WIDTH-1:0]  req_wdata,
    output op_t                    req_op,
    output logic                   busy,
    output logic [DATA_WIDTH-1:0]  rdata,
    output logic                   rvalid,
    output logic                   err
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending   <= 1'b0;
            req_haddr <= '0;
            req_wdata <= '0;
            req_op    <= OP_RD;
            busy      <= 1'b0;
            rdata     <= '0;
            rvalid    <= 1'b0;
            err       <= 1'b0;
        end else begin
            rvalid <= 1'b0;
            err    <= 1'b0;
            if (!busy && (rd_enable || wr_enable)) begin
                // Write wins when both strobes arrive together.
                pending   <= 1'b1;
                busy      <= 1'b1;
                req_haddr <= haddr;
                req_wdata <= wdata;
                req_op    <= wr_enable ? OP_WR : OP_RD;
            end else if (busy) begin
                if (grant) begin
                    pending <= 1'b0;
                end
                if (done) begin
                    busy <= 1'b0;
                    if (req_op == OP_RD) begin
                        rdata  <= data_output;
                        rvalid <= 1'b1;
                    end
                end else if (abort) begin
                    busy <= 1'b0;
                    err  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sdram_host_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller host interface between two ports;
// one controller op in flight, with an ack timeout if the controller never goes busy.
module sdram_host_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int HADDR_WIDTH  = 24,
    parameter int DATA_WIDTH   = 16,
    parameter int ACK_TO_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [HADDR_WIDTH-1:0] p0_haddr,
    input  logic [DATA_WIDTH-1:0]  p0_wdata,
    input  logic                   p0_rd_enable,
    input  logic                   p0_wr_enable,
    output logic                   p0_busy,
    output logic [DATA_WIDTH-1:0]  p0_rdata,
    output logic                   p0_rvalid,
    output logic                   p0_err,
    input  logic [HADDR_WIDTH-1:0] p1_haddr,
    input  logic [DATA_WIDTH-1:0]  p1_wdata,
    input  logic                   p1_rd_enable,
    input  logic                   p1_wr_enable,
    output logic                   p1_busy,
    output logic [DATA_WIDTH-1:0]  p1_rdata,
    output logic                   p1_rvalid,
    output logic                   p1_err,
    sdram_host_arbiter_if.master   host,
    output arb_state_t             state_dbg
);

    localparam logic [ACK_TO_WIDTH-1:0] CNT_ONE = 1;

    arb_state_t              state;
    logic                    owner;
    logic                    last_grant;
    logic [ACK_TO_WIDTH-1:0] cnt;
    logic [ACK_TO_WIDTH-1:0] cnt_inc;
    logic [HADDR_WIDTH-1:0]  haddr_q;
    logic [DATA_WIDTH-1:0]   data_input_q;
    logic                    rd_enable_q;
    logic                    wr_enable_q;

    logic                    pend0, pend1;
    logic [HADDR_WIDTH-1:0]  req_haddr0, req_haddr1, sel_haddr;
    logic [DATA_WIDTH-1:0]   req_wdata0, req_wdata1, sel_wdata;
    op_t                     req_op0, req_op1, sel_op;
    logic                    grant_valid, grant_sel;
    logic                    op_done, abort_hit;

    // Both pending: the port not served last time goes first.
    always_comb begin
        grant_sel = 1'b0;
        if (pend0 && pend1) begin
            grant_sel = ~last_grant;
        end else if (pend1) begin
            grant_sel = 1'b1;
        end
    end

    assign grant_valid = (state == IDLE) && (pend0 || pend1);
    assign sel_haddr   = grant_sel ? req_haddr1 : req_haddr0;
    assign sel_wdata   = grant_sel ? req_wdata1 : req_wdata0;
    assign sel_op      = grant_sel ? req_op1 : req_op0;
    assign cnt_inc     = cnt + CNT_ONE;
    assign op_done     = (state == WAIT_DONE) && !host.busy;
    assign abort_hit   = (state == WAIT_ACK) && !host.busy && (cnt_inc == '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            owner        <= 1'b0;
            last_grant   <= 1'b1;
            cnt          <= '0;
            haddr_q      <= '0;
            data_input_q <= '0;
            rd_enable_q  <= 1'b0;
            wr_enable_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        state        <= ISSUE;
                        owner        <= grant_sel;
                        last_grant   <= grant_sel;
                        haddr_q      <= sel_haddr;
                        data_input_q <= sel_wdata;
                        rd_enable_q  <= (sel_op == OP_RD);
                        wr_enable_q  <= (sel_op == OP_WR);
                    end
                end
                ISSUE: begin
                    rd_enable_q <= 1'b0;
                    wr_enable_q <= 1'b0;
                    cnt         <= '0;
                    state       <= host.busy ? WAIT_DONE : WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (host.busy) begin
                        state <= WAIT_DONE;
                    end else if (abort_hit) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                WAIT_DONE: begin
                    if (!host.busy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign host.haddr      = haddr_q;
    assign host.data_input = data_input_q;
    assign host.rd_enable  = rd_enable_q;
    assign host.wr_enable  = wr_enable_q;
    assign state_dbg       = state;

    sdram_arb_port #(
        .HADDR_WIDTH (HADDR_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH)
    ) u_port0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_enable   (p0_rd_enable),
        .wr_enable   (p0_wr_enable),
        .haddr       (p0_haddr),
        .wdata       (p0_wdata),
        .grant       (grant_valid && !grant_sel),
        .done        (op_done && !owner),
        .abort       (abort_hit && !owner),
        .data_output (host.data_output),
        .pending     (pend0),
        .req_haddr   (req_haddr0),
        .req_wdata   (req_wdata0),
        .req_op      (req_op0),
        .busy        (p0_busy),
        .rdata       (p0_rdata),
        .rvalid      (p0_rvalid),
        .err         (p0_err)
    );

    sdram_arb_port #(
        .HADDR_WIDTH (HADDR_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH)
    ) u_port1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_enable   (p1_rd_enable),
        .wr_enable   (p1_wr_enable),
        .haddr       (p1_haddr),
        .wdata       (p1_wdata),
        .grant       (grant_valid && grant_sel),
        .done        (op_done && owner),
        .abort       (abort_hit && owner),
        .data_output (host.data_output),
        .pending     (pend1),
        .req_haddr   (req_haddr1),
        .req_wdata   (req_wdata1),
        .req_op      (req_op1),
        .busy        (p1_busy),
        .rdata       (p1_rdata),
        .rvalid      (p1_rvalid),
        .err         (p1_err)
    );

endmodule

// File: tb/tb_sdram_host_arbiter.sv
// Directed bench for sdram_host_arbiter: the bench plays the SDRAM controller by hand.
module tb_sdram_host_arbiter;
  import sdram_arb_pkg::*;

  localparam int HW = 24;
  localparam int DW = 16;

  logic          clk;
  logic          rst_n;
  logic [HW-1:0] p0_haddr, p1_haddr;
  logic [DW-1:0] p0_wdata, p1_wdata;
  logic          p0_rd_enable, p0_wr_enable, p1_rd_enable, p1_wr_enable;
  logic          p0_busy, p0_rvalid, p0_err, p1_busy, p1_rvalid, p1_err;
  logic [DW-1:0] p0_rdata, p1_rdata;
  arb_state_t    state_dbg;

  int checks;
  int failures;

  sdram_host_arbiter_if #(.HADDR_WIDTH(HW), .DATA_WIDTH(DW)) hif ();

  sdram_host_arbiter #(.HADDR_WIDTH(HW), .DATA_WIDTH(DW), .ACK_TO_WIDTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .p0_haddr     (p0_haddr),
    .p0_wdata     (p0_wdata),
    .p0_rd_enable (p0_rd_enable),
    .p0_wr_enable (p0_wr_enable),
    .p0_busy      (p0_busy),
    .p0_rdata     (p0_rdata),
    .p0_rvalid    (p0_rvalid),
    .p0_err       (p0_err),
    .p1_haddr     (p1_haddr),
    .p1_wdata     (p1_wdata),
    .p1_rd_enable (p1_rd_enable),
    .p1_wr_enable (p1_wr_enable),
    .p1_busy      (p1_busy),
    .p1_rdata     (p1_rdata),
    .p1_rvalid    (p1_rvalid),
    .p1_err       (p1_err),
    .host         (hif.master),
    .state_dbg    (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_haddr"}, 32'(hif.haddr), 32'h0);
    check({tag, "_data_input"}, 32'(hif.data_input), 32'h0);
    check({tag, "_rd_en"}, 32'(hif.rd_enable), 32'h0);
    check({tag, "_wr_en"}, 32'(hif.wr_enable), 32'h0);
    check({tag, "_p0_busy"}, 32'(p0_busy), 32'h0);
    check({tag, "_p1_busy"}, 32'(p1_busy), 32'h0);
    check({tag, "_p0_rdata"}, 32'(p0_rdata), 32'h0);
    check({tag, "_p1_rdata"}, 32'(p1_rdata), 32'h0);
    check({tag, "_rvalid"}, 32'({p0_rvalid, p1_rvalid}), 32'h0);
    check({tag, "_err"}, 32'({p0_err, p1_err}), 32'h0);
    check({tag, "_state"}, 32'(state_dbg), 32'(IDLE));
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    p0_haddr = '0; p0_wdata = '0; p0_rd_enable = 1'b0; p0_wr_enable = 1'b0;
    p1_haddr = '0; p1_wdata = '0; p1_rd_enable = 1'b0; p1_wr_enable = 1'b0;
    hif.busy = 1'b0;
    hif.data_output = '0;
    tick(2);
    check_outputs_zero("reset");
    rst_n = 1'b1;

    // p0 write, controller busy one cycle after the enable, four cycles long
    p0_wr_enable = 1'b1; p0_haddr = 24'h000010; p0_wdata = 16'hA5A5;
    tick(1);
    p0_wr_enable = 1'b0;
    check("s1_p0_busy_cap", 32'(p0_busy), 32'h1);
    check("s1_no_enable_yet", 32'(hif.wr_enable), 32'h0);
    tick(1);
    check("s1_wr_en", 32'(hif.wr_enable), 32'h1);
    check("s1_rd_en", 32'(hif.rd_enable), 32'h0);
    check("s1_haddr", 32'(hif.haddr), 32'h10);
    check("s1_data_input", 32'(hif.data_input), 32'hA5A5);
    check("s1_state_issue", 32'(state_dbg), 32'(ISSUE));
    tick(1);
    check("s1_wr_en_drop", 32'(hif.wr_enable), 32'h0);
    check("s1_state_ack", 32'(state_dbg), 32'(WAIT_ACK));
    hif.busy = 1'b1;
    tick(1);
    check("s1_state_done", 32'(state_dbg), 32'(WAIT_DONE));
    tick(3);
    check("s1_p0_busy_held", 32'(p0_busy), 32'h1);
    hif.busy = 1'b0;
    tick(1);
    check("s1_p0_busy_fall", 32'(p0_busy), 32'h0);
    check("s1_no_rvalid", 32'(p0_rvalid), 32'h0);
    check("s1_idle", 32'(state_dbg), 32'(IDLE));
    check("s1_haddr_hold", 32'(hif.haddr), 32'h10);

    // p1 read
    p1_rd_enable = 1'b1; p1_haddr = 24'h0000FF;
    tick(1);
    p1_rd_enable = 1'b0;
    check("s2_p1_busy", 32'(p1_busy), 32'h1);
    tick(1);
    check("s2_rd_en", 32'(hif.rd_enable), 32'h1);
    check("s2_wr_en", 32'(hif.wr_enable), 32'h0);
    check("s2_haddr", 32'(hif.haddr), 32'hFF);
    hif.busy = 1'b1;
    tick(1);
    check("s2_rd_en_drop", 32'(hif.rd_enable), 32'h0);
    tick(2);
    hif.busy = 1'b0; hif.data_output = 16'h1234;
    tick(1);
    check("s2_p1_rvalid", 32'(p1_rvalid), 32'h1);
    check("s2_p1_rdata", 32'(p1_rdata), 32'h1234);
    check("s2_p1_busy_fall", 32'(p1_busy), 32'h0);
    check("s2_p0_rvalid", 32'(p0_rvalid), 32'h0);
    tick(1);
    check("s2_p1_rvalid_pulse", 32'(p1_rvalid), 32'h0);
    check("s2_p1_rdata_hold", 32'(p1_rdata), 32'h1234);

    // simultaneous requests straight after reset: p0 first
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    p0_rd_enable = 1'b1; p0_haddr = 24'h000020;
    p1_wr_enable = 1'b1; p1_haddr = 24'h000030; p1_wdata = 16'hBEEF;
    tick(1);
    p0_rd_enable = 1'b0; p1_wr_enable = 1'b0;
    tick(1);
    check("s3_first_haddr", 32'(hif.haddr), 32'h20);
    check("s3_first_rd_en", 32'(hif.rd_enable), 32'h1);
    check("s3_p1_waiting", 32'(p1_busy), 32'h1);
    hif.busy = 1'b1;
    tick(1);
    hif.busy = 1'b0; hif.data_output = 16'h5555;
    tick(1);
    check("s3_p0_rvalid", 32'(p0_rvalid), 32'h1);
    check("s3_p0_rdata", 32'(p0_rdata), 32'h5555);
    check("s3_p1_still_busy", 32'(p1_busy), 32'h1);
    tick(1);
    check("s3_second_wr_en", 32'(hif.wr_enable), 32'h1);
    check("s3_second_haddr", 32'(hif.haddr), 32'h30);
    check("s3_second_data", 32'(hif.data_input), 32'hBEEF);
    hif.busy = 1'b1;
    tick(1);
    hif.busy = 1'b0;
    tick(1);
    check("s3_p1_done", 32'(p1_busy), 32'h0);
    check("s3_p1_no_rvalid", 32'(p1_rvalid), 32'h0);

    // a lone p0 op leaves p0 as last granted, so the next contest goes to p1
    p0_wr_enable = 1'b1; p0_haddr = 24'h000060; p0_wdata = 16'h6666;
    tick(1);
    p0_wr_enable = 1'b0;
    tick(1);
    check("s3_solo_haddr", 32'(hif.haddr), 32'h60);
    hif.busy = 1'b1;
    tick(1);
    hif.busy = 1'b0;
    tick(1);
    check("s3_solo_done", 32'(p0_busy), 32'h0);
    p0_rd_enable = 1'b1; p0_haddr = 24'h000040;
    p1_rd_enable = 1'b1; p1_haddr = 24'h000050;
    tick(1);
    p0_rd_enable = 1'b0; p1_rd_enable = 1'b0;
    tick(1);
    check("s3r_first_haddr", 32'(hif.haddr), 32'h50);
    check("s3r_first_rd_en", 32'(hif.rd_enable), 32'h1);
    hif.busy = 1'b1;
    tick(1);
    hif.busy = 1'b0; hif.data_output = 16'h7777;
    tick(1);
    check("s3r_p1_rvalid", 32'(p1_rvalid), 32'h1);
    check("s3r_p1_rdata", 32'(p1_rdata), 32'h7777);
    check("s3r_p0_rvalid", 32'(p0_rvalid), 32'h0);
    tick(1);
    check("s3r_second_haddr", 32'(hif.haddr), 32'h40);
    check("s3r_second_rd_en", 32'(hif.rd_enable), 32'h1);
    hif.busy = 1'b1;
    tick(1);
    hif.busy = 1'b0; hif.data_output = 16'h8888;
    tick(1);
    check("s3r_p0_rvalid", 32'(p0_rvalid), 32'h1);
    check("s3r_p0_rdata", 32'(p0_rdata), 32'h8888);

    // ack timeout: controller never goes busy
    p0_rd_enable = 1'b1; p0_haddr = 24'h000070;
    tick(1);
    p0_rd_enable = 1'b0;
    tick(2);
    check("s4_enter_ack", 32'(state_dbg), 32'(WAIT_ACK));
    tick(14);
    check("s4_still_ack", 32'(state_dbg), 32'(WAIT_ACK));
    check("s4_no_err_early", 32'(p0_err), 32'h0);
    check("s4_busy_early", 32'(p0_busy), 32'h1);
    tick(1);
    check("s4_err", 32'(p0_err), 32'h1);
    check("s4_busy_clear", 32'(p0_busy), 32'h0);
    check("s4_idle", 32'(state_dbg), 32'(IDLE));
    check("s4_no_rvalid", 32'(p0_rvalid), 32'h0);
    tick(1);
    check("s4_err_pulse", 32'(p0_err), 32'h0);

    // rd+wr together: write taken; a read while busy is ignored
    p0_rd_enable = 1'b1; p0_wr_enable = 1'b1; p0_haddr = 24'h000080; p0_wdata = 16'h0F0F;
    tick(1);
    p0_wr_enable = 1'b0; p0_haddr = 24'h000090;
    check("s5_busy", 32'(p0_busy), 32'h1);
    tick(1);
    check("s5_wr_en", 32'(hif.wr_enable), 32'h1);
    check("s5_rd_en", 32'(hif.rd_enable), 32'h0);
    check("s5_haddr", 32'(hif.haddr), 32'h80);
    check("s5_data", 32'(hif.data_input), 32'h0F0F);
    hif.busy = 1'b1;
    tick(1);
    p0_rd_enable = 1'b0; hif.busy = 1'b0;
    tick(1);
    check("s5_done", 32'(p0_busy), 32'h0);
    check("s5_no_rvalid", 32'(p0_rvalid), 32'h0);
    p0_wr_enable = 1'b1; p0_haddr = 24'h0000A0; p0_wdata = 16'h0A0A;
    tick(1);
    p0_wr_enable = 1'b0;
    check("s5_rereq_busy", 32'(p0_busy), 32'h1);
    check("s5_ignored_not_issued", 32'(state_dbg), 32'(IDLE));
    tick(1);
    check("s5_rereq_haddr", 32'(hif.haddr), 32'hA0);
    check("s5_rereq_wr_en", 32'(hif.wr_enable), 32'h1);
    hif.busy = 1'b1;
    tick(1);
    hif.busy = 1'b0;
    tick(1);
    check("s5_rereq_done", 32'(p0_busy), 32'h0);

    // async reset in WAIT_DONE
    p1_rd_enable = 1'b1; p1_haddr = 24'h0000B0;
    tick(1);
    p1_rd_enable = 1'b0;
    tick(1);
    hif.busy = 1'b1;
    tick(1);
    check("s6_in_done", 32'(state_dbg), 32'(WAIT_DONE));
    #2 rst_n = 1'b0;
    #1;
    check_outputs_zero("s6_rst");
    hif.busy = 1'b0; hif.data_output = 16'hDEAD;
    tick(1);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("s6_no_rvalid", 32'(p1_rvalid), 32'h0);
      check("s6_p1_idle", 32'(p1_busy), 32'h0);
    end
    check("s6_p1_rdata", 32'(p1_rdata), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
